adder_rr_scheduler: RTL and testbench

- Shares one 32-bit CarrySelectAdder instance between N requesters.
- Round-robin arbitration; one add accepted per cycle.
- The result is registered in a single output slot with a valid/ready handshake and tagged with the requester ID.
- Sits between the ALU issue logic and the adder datapath; it is the only driver of the adder's A, B and Cin inputs.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/CarrySelectAdder.sv | 39 +++
 rtl/adder_rr_scheduler_rr_arbiter.sv | 38 +++
 rtl/adder_rr_scheduler.sv | 101 ++++++++++
 tb/tb_adder_rr_scheduler.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg                                                              |
// | Shared ALU constants, slot result record and one-hot index helper.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int MAX_IDW = 4;

  typedef struct packed {
    logic [DATA_W-1:0]  sum;
    logic               cout;
    logic               ovf;
    logic [MAX_IDW-1:0] id;
  } res_t;

  function automatic logic [MAX_IDW-1:0] onehot_to_idx(input logic [15:0] oh);
    logic [MAX_IDW-1:0] r_idx;
    r_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) r_idx = r_idx | MAX_IDW'(i);
    end
    return r_idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/CarrySelectAdder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | CarrySelectAdder                                                     |
// | 32-bit carry-select adder, 4-bit blocks, with carry-out and signed   |
// | overflow. Revision: 1.0                                              |
// +----------------------------------------------------------------------+
module CarrySelectAdder
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              cout,
  output logic              ovf
);

  localparam int C_BLK   = 4;
  localparam int C_NBLK  = DATA_W / C_BLK;

  logic [C_NBLK:0] w_c;

  assign w_c[0] = cin;

  // Each block precomputes both carry-in cases; the incoming carry only picks one.
  for (genvar g = 0; g < C_NBLK; g++) begin : g_blk
    logic [C_BLK:0] w_s0;
    logic [C_BLK:0] w_s1;
    assign w_s0 = {1'b0, a[g*C_BLK +: C_BLK]} + {1'b0, b[g*C_BLK +: C_BLK]};
    assign w_s1 = {1'b0, a[g*C_BLK +: C_BLK]} + {1'b0, b[g*C_BLK +: C_BLK]} + (C_BLK+1)'(1);
    assign sum[g*C_BLK +: C_BLK] = w_c[g] ? w_s1[C_BLK-1:0] : w_s0[C_BLK-1:0];
    assign w_c[g+1]              = w_c[g] ? w_s1[C_BLK]     : w_s0[C_BLK];
  end

  assign cout = w_c[C_NBLK];
  assign ovf  = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);

endmodule
`default_nettype wire

// File: rtl/adder_rr_scheduler_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter                                                           |
// | Combinational round-robin pick starting at ptr; one-hot + index.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_arbiter
  import alu_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           enable,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx
);

  logic [15:0]        w_oh;
  logic [MAX_IDW-1:0] w_idx_full;

  always_comb begin
    gnt = '0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (enable && req[j] && (gnt == '0)) gnt[j] = 1'b1;
    end
  end

  assign w_oh       = 16'(gnt);
  assign w_idx_full = onehot_to_idx(w_oh);
  assign idx        = w_idx_full[IDW-1:0];

endmodule
`default_nettype wire

// File: rtl/adder_rr_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_rr_scheduler                                                   |
// | Round-robin sharing of one adder among N requesters, single output   |
// | slot with valid/ready. Revision: 1.0                                 |
// +----------------------------------------------------------------------+
module adder_rr_scheduler
  import alu_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  input  logic [N*DATA_W-1:0] req_a,
  input  logic [N*DATA_W-1:0] req_b,
  input  logic [N-1:0]        req_cin,
  output logic [N-1:0]        gnt,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [DATA_W-1:0]   res_sum,
  output logic                res_cout,
  output logic                res_ovf,
  output logic [IDW-1:0]      res_id
);

  logic              r_valid;
  res_t              r_res;
  logic [IDW-1:0]    r_ptr;

  logic              w_can_accept;
  logic              w_enable;
  logic              w_accept;
  logic [IDW-1:0]    w_idx;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic              w_cin;
  logic [DATA_W-1:0] w_sum;
  logic              w_cout;
  logic              w_ovf;

  // A pop and a fresh accept share a cycle, so a draining slot never bubbles.
  assign w_can_accept = !r_valid || res_ready;
  assign w_enable     = w_can_accept && !rst;
  assign w_accept     = |gnt;

  rr_arbiter #(.N(N)) u_arb (
    .req    (req),
    .ptr    (r_ptr),
    .enable (w_enable),
    .gnt    (gnt),
    .idx    (w_idx)
  );

  // Operands held at zero without a grant keep the adder quiet.
  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_cin = 1'b0;
    if (w_accept) begin
      w_a   = req_a[int'(w_idx)*DATA_W +: DATA_W];
      w_b   = req_b[int'(w_idx)*DATA_W +: DATA_W];
      w_cin = req_cin[w_idx];
    end
  end

  CarrySelectAdder u_add (
    .a    (w_a),
    .b    (w_b),
    .cin  (w_cin),
    .sum  (w_sum),
    .cout (w_cout),
    .ovf  (w_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_res   <= '0;
      r_ptr   <= '0;
    end else if (w_accept) begin
      r_valid      <= 1'b1;
      r_res.sum    <= w_sum;
      r_res.cout   <= w_cout;
      r_res.ovf    <= w_ovf;
      r_res.id     <= MAX_IDW'(w_idx);
      r_ptr        <= (w_idx == IDW'(N-1)) ? '0 : w_idx + IDW'(1);
    end else if (res_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign res_valid = r_valid;
  assign res_sum   = r_res.sum;
  assign res_cout  = r_res.cout;
  assign res_ovf   = r_res.ovf;
  assign res_id    = r_res.id[IDW-1:0];

endmodule
`default_nettype wire

// File: tb/tb_adder_rr_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_adder_rr_scheduler                                                |
// | Directed and random checks against a behavioural scheduler model.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_adder_rr_scheduler;

  localparam int N   = 4;
  localparam int IDW = $clog2(N);

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N*32-1:0]   req_a;
  logic [N*32-1:0]   req_b;
  logic [N-1:0]      req_cin;
  logic [N-1:0]      gnt;
  logic              res_valid;
  logic              res_ready;
  logic [31:0]       res_sum;
  logic              res_cout;
  logic              res_ovf;
  logic [IDW-1:0]    res_id;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  bit        m_known = 0;
  bit        m_valid;
  bit [31:0] m_sum;
  bit        m_cout;
  bit        m_ovf;
  int        m_id;
  int        m_ptr;

  adder_rr_scheduler #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_ovf   (res_ovf),
    .res_id    (res_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic c);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_cin[i]        = c;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance it.
  task automatic cycle();
    logic [N-1:0] eg;
    int           gi;
    bit           can;
    bit   [32:0]  s;
    logic [31:0]  a, b;
    @(negedge clk);
    can = !m_valid || res_ready;
    gi  = -1;
    eg  = '0;
    if (!rst && m_known && can) begin
      for (int d = 0; d < N; d++) begin
        int j;
        j = (m_ptr + d) % N;
        if (gi < 0 && req[j]) gi = j;
      end
    end
    if (gi >= 0) eg[gi] = 1'b1;
    if (m_known || rst) chk("gnt", 64'(gnt), 64'(eg));
    if (m_known) begin
      chk("res_valid", 64'(res_valid), 64'(m_valid));
      if (m_valid) begin
        chk("res_sum",  64'(res_sum),  64'(m_sum));
        chk("res_cout", 64'(res_cout), 64'(m_cout));
        chk("res_ovf",  64'(res_ovf),  64'(m_ovf));
        chk("res_id",   64'(res_id),   64'(m_id));
      end
    end
    @(posedge clk);
    if (rst) begin
      m_known = 1; m_valid = 0; m_sum = 0; m_cout = 0; m_ovf = 0; m_id = 0; m_ptr = 0;
    end else if (gi >= 0) begin
      a       = req_a[32*gi +: 32];
      b       = req_b[32*gi +: 32];
      s       = {1'b0, a} + {1'b0, b} + 33'(req_cin[gi]);
      m_valid = 1;
      m_sum   = s[31:0];
      m_cout  = s[32];
      m_ovf   = (a[31] == b[31]) && (s[31] != a[31]);
      m_id    = gi;
      m_ptr   = (gi + 1) % N;
    end else if (res_ready) begin
      m_valid = 0;
    end
    #1;
  endtask

  initial begin
    rst = 1; req = '0; req_a = '0; req_b = '0; req_cin = '0; res_ready = 1;
    cycle();
    cycle();
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_sum",   64'(res_sum),   64'd0);
    chk("rst_cout",  64'(res_cout),  64'd0);
    chk("rst_ovf",   64'(res_ovf),   64'd0);
    chk("rst_id",    64'(res_id),    64'd0);
    rst = 0;

    // 5 + 3
    set_op(0, 32'h5, 32'h3, 1'b0);
    req = 4'b0001;
    cycle();
    req = '0;
    chk("t1_valid", 64'(res_valid), 64'd1);
    chk("t1_sum",   64'(res_sum),   64'h8);
    chk("t1_id",    64'(res_id),    64'd0);

    // back-to-back round robin from a fresh pointer
    rst = 1; cycle(); rst = 0;
    for (int i = 0; i < N; i++) set_op(i, $urandom, $urandom, 1'($urandom));
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("rr_valid", 64'(res_valid), 64'd1);
      chk("rr_id",    64'(res_id),    64'(k % 4));
    end
    req = '0;
    cycle();

    // signed overflow
    set_op(2, 32'h7FFF_FFFF, 32'h1, 1'b0);
    req = 4'b0100;
    cycle();
    req = '0;
    chk("ovf_sum",  64'(res_sum),  64'h8000_0000);
    chk("ovf_ovf",  64'(res_ovf),  64'd1);
    chk("ovf_cout", 64'(res_cout), 64'd0);

    // carry out with cin
    set_op(1, 32'hFFFF_FFFF, 32'h1, 1'b1);
    req = 4'b0010;
    cycle();
    chk("co_sum",  64'(res_sum),  64'h1);
    chk("co_cout", 64'(res_cout), 64'd1);
    chk("co_ovf",  64'(res_ovf),  64'd0);

    // backpressure: slot full holding requester 1's result
    res_ready = 0;
    req = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_sum", 64'(res_sum), 64'h1);
      chk("bp_id",  64'(res_id),  64'd1);
    end
    res_ready = 1;
    cycle();
    chk("bp_next_id", 64'(res_id), 64'd2);

    // reset while full and requesting
    res_ready = 0;
    rst = 1;
    cycle();
    chk("mid_rst_valid", 64'(res_valid), 64'd0);
    rst = 0;
    res_ready = 1;
    cycle();
    chk("post_rst_id", 64'(res_id), 64'd0);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) set_op(i, $urandom, $urandom, 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        set_op($urandom_range(0, N-1), 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
      end
      req       = N'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 49) == 0);
      cycle();
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
